// File: rtl/scr1_acc_copy.sv
// scr1_acc_copy: memory-mapped word copy/fill engine sitting beside the TCM.
// The CPU programs SRC/DST/LEN/FILL/mode through a 32-byte register window and
// writes START. The engine then walks LEN words through a single-port memory
// port in strict ascending order. Copy takes 2 cycles per word (RD then WR)
// and fill takes 1 cycle per word (WR only).
module scr1_acc_copy #(
  parameter logic [31:0] BASE_ADDR = 32'hF010_0000,
  parameter int          MEM_AW    = 14,
  parameter int          LEN_W     = 16,
  parameter int          DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_sel,
  input  logic              bus_we,
  input  logic [31:0]       bus_addr,
  input  logic [DATA_W-1:0] bus_wdata,
  output logic [DATA_W-1:0] bus_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              irq
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   src_r, dst_r, fill_r;
  logic [LEN_W-1:0]    len_r;
  logic                ctrl_mode, ctrl_irq_en;
  logic                done, err;
  logic [MEM_AW-1:0]   wsrc, wdst;
  logic [LEN_W-1:0]    wcnt;

  logic                hit, wr_hit, rd_hit, ctrl_wr, cfg_wr;
  logic                busy, start_acc, clr, err_set;
  logic [2:0]          off;
  logic [DATA_W-1:0]   status, rdata_d;
  logic                unused_addr_lsb;

  assign unused_addr_lsb = ^bus_addr[1:0];

  assign hit     = bus_sel && (bus_addr[31:5] == BASE_ADDR[31:5]);
  assign off     = bus_addr[4:2];
  assign wr_hit  = hit && bus_we;
  assign rd_hit  = hit && !bus_we;
  assign ctrl_wr = wr_hit && (off == 3'd0);
  assign cfg_wr  = wr_hit && (off == 3'd1 || off == 3'd2 || off == 3'd3 || off == 3'd5);

  assign busy      = (state_q == RD) || (state_q == WR);
  assign start_acc = ctrl_wr && bus_wdata[0] && (state_q == IDLE);
  assign clr       = ctrl_wr && bus_wdata[3];
  // Reconfiguration attempts while a transfer runs are dropped and flagged.
  // An irq_en update or a clr alone is harmless and does not flag.
  assign err_set   = busy && (cfg_wr ||
                     (ctrl_wr && (bus_wdata[0] || (bus_wdata[1] != ctrl_mode))));

  assign irq = done && ctrl_irq_en;

  // Build the status word and the read-data mux for the register window.
  always_comb begin
    status                = '0;
    status[0]             = busy;
    status[1]             = done;
    status[2]             = err;
    status[16 +: LEN_W]   = wcnt;
    rdata_d               = '0;
    case (off)
      3'd1:    rdata_d = src_r;
      3'd2:    rdata_d = dst_r;
      3'd3:    rdata_d = DATA_W'(len_r);
      3'd4:    rdata_d = status;
      3'd5:    rdata_d = fill_r;
      default: rdata_d = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and memory port drive. The memory port is a pure function of the state.
  always_comb begin
    state_d   = state_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      IDLE: begin
        // The mode bit comes from the same write, so "mode+start" in one write works.
        if (start_acc) begin
          if (len_r == '0)       state_d = DONE;
          else if (bus_wdata[1]) state_d = WR;
          else                   state_d = RD;
        end
      end
      RD: begin
        mem_en   = 1'b1;
        mem_addr = wsrc;
        state_d  = WR;
      end
      WR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = wdst;
        mem_wdata = ctrl_mode ? fill_r : mem_rdata;
        if (wcnt == LEN_W'(1)) state_d = DONE;
        else if (!ctrl_mode)   state_d = RD;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Register window, status flags and working counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_rdata   <= '0;
      src_r       <= '0;
      dst_r       <= '0;
      len_r       <= '0;
      fill_r      <= '0;
      ctrl_mode   <= 1'b0;
      ctrl_irq_en <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      wsrc        <= '0;
      wdst        <= '0;
      wcnt        <= '0;
    end else begin
      if (rd_hit) bus_rdata <= rdata_d;

      if (ctrl_wr) begin
        ctrl_irq_en <= bus_wdata[2];
        if (!busy) ctrl_mode <= bus_wdata[1];
      end

      if (cfg_wr && !busy) begin
        case (off)
          3'd1:    src_r  <= bus_wdata;
          3'd2:    dst_r  <= bus_wdata;
          3'd3:    len_r  <= bus_wdata[LEN_W-1:0];
          3'd5:    fill_r <= bus_wdata;
          default: ;
        endcase
      end

      // done: set on leaving DONE. It is cleared by an accepted start or by an idle clr.
      if (state_q == DONE)               done <= 1'b1;
      else if (start_acc || (clr && !busy)) done <= 1'b0;

      // err: a fresh violation wins over a clr in the same write.
      if (err_set)  err <= 1'b1;
      else if (clr) err <= 1'b0;

      if (start_acc) begin
        wsrc <= src_r[MEM_AW+1:2];
        wdst <= dst_r[MEM_AW+1:2];
        wcnt <= len_r;
      end else if (state_q == WR) begin
        wsrc <= wsrc + MEM_AW'(1);
        wdst <= wdst + MEM_AW'(1);
        wcnt <= wcnt - LEN_W'(1);
      end
    end
  end

endmodule

// File: doc/scr1_acc_copy.md
Name: scr1_acc_copy

Overview:
- Memory-mapped word-copy/fill engine for the TCM region; successor of the single-word ACC copy block.
- CPU programs source, destination, length and mode through a register window, then writes START.
- Engine moves LEN words through a dedicated single-port memory port and reports busy/done/error status, with an optional interrupt.
- Sits beside the TCM, with its memory port arbitrated into the TCM.

Parameters:
- BASE_ADDR, 32'hF010_0000, base of 32-byte register window; decode is bus_addr[31:5]==BASE_ADDR[31:5]
- MEM_AW, 14, memory word-address width (byte address bits [MEM_AW+1:2])
- LEN_W, 16, width of length register (max LEN_W'1 words per transfer)
- DATA_W, 32, memory/bus data width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- bus_sel  in  1  register-access strobe, single-cycle
- bus_we  in  1  1=write, 0=read
- bus_addr  in  32  byte address
- bus_wdata  in  DATA_W  write data
- bus_rdata  out  DATA_W  read data, valid the cycle after bus_sel&!bus_we
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable (4 byte lanes always written)
- mem_addr  out  MEM_AW  memory word address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, 1-cycle latency after mem_en&!mem_we
- irq  out  1  level interrupt = STATUS.done & CTRL.irq_en

Behaviour:
- Register map (offset = bus_addr[4:2]*4):
  - 0x00 CTRL, W. bit0 start (self-clearing pulse), bit1 mode (0 copy, 1 fill), bit2 irq_en (sticky), bit3 clr (clears done/err).
  - 0x04 SRC, RW. Byte address; bits [MEM_AW+1:2] used.
  - 0x08 DST, RW. Byte address; bits [MEM_AW+1:2] used.
  - 0x0C LEN, RW. Word count.
  - 0x10 STATUS, R. bit0 busy, bit1 done, bit2 err, bits[31:16] remaining count.
  - 0x14 FILL, RW. Fill pattern.
  - Offsets 0x18/0x1C read 0, writes ignored.
- Out-of-window accesses are ignored; bus_rdata holds its last value.
- Reset: FSM IDLE; all registers 0; bus_rdata=0; mem_en=mem_we=0; mem_addr=0; mem_wdata=0; irq=0.
- FSM states: IDLE, RD, WR, DONE.
  - IDLE + start + LEN!=0: latch working copies of src/dst/cnt. Copy mode goes to RD; fill mode goes to WR.
  - IDLE + start + LEN==0: go directly to DONE; no memory access.
  - RD (copy only): mem_en=1, mem_we=0, mem_addr=src. Next state WR.
  - WR: mem_en=1, mem_we=1, mem_addr=dst.
    - mem_wdata = mem_rdata in copy mode, FILL in fill mode.
    - Then src+=1, dst+=1, cnt-=1.
    - If cnt==1 before decrement, go to DONE; else copy goes to RD, fill stays in WR.
  - DONE: set done=1, busy=0. Next state IDLE.
- Throughput: copy is 2 cycles/word; fill is 1 cycle/word. Copy total = 2*LEN+1 cycles from start write to done visible.
- busy=1 in RD/WR; done is sticky until clr, or until a new start is accepted (start clears done).
- Word addresses wrap modulo 2^MEM_AW; no error is raised on wrap.
- Writes to SRC/DST/LEN/FILL/CTRL.mode while busy are ignored and set err. A start while busy is ignored and sets err. clr is honoured while busy (clears err only) and never aborts.
- Simultaneous clr+start in IDLE: clear first, then start.
- A read of STATUS in the same cycle done sets returns the pre-update value.
- rst asserted mid-transfer aborts immediately. mem_en drops the next edge, and all state returns to reset values.
- Overlapping src/dst regions: strict ascending word order, no hazard handling. Results are defined by that order.

Test Plan:
- Copy: SRC=0x100, DST=0x200, LEN=4, mem[0x40..0x43]=A0..A3, start → mem[0x80..0x83]=A0..A3; done set 9 cycles after start; busy high 8 cycles.
- Fill: FILL=0xDEADBEEF, DST=0x0, LEN=3, mode=1, start → words 0..2 = DEADBEEF, 3 write cycles, no reads; irq high if irq_en=1, cleared by clr.
- LEN=0: start → done next cycle, mem_en never asserted.
- Wrap: DST=0xFFFC (word 0x3FFF), LEN=2 fill → writes to words 0x3FFF then 0x0000.
- Busy violations: during a LEN=8 copy, write LEN=1 and start → err=1, transfer still moves 8 words, LEN reads back 8.
- Reset mid-op: assert rst at 3rd word of a LEN=8 copy → next cycle mem_en=0; STATUS=0, irq=0; later start runs correctly from fresh config.
